mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port 512x16 data/instruction RAM between two requesters: master 0 (CPU fetch/load/store port) and master 1 (I/O or DMA engine).
- Each master issues one-hot mem_cmd style requests (MNONE 3'b001, MREAD 3'b010, MWRITE 3'b100).
- The arbiter grants round-robin, runs one RAM access at a time, and returns an ack pulse plus read data.
- Sits between the masters and the RAM instance at top level.

Parameters:
AW, 9, address width
DW, 16, data width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; forces all state to reset values immediately
m0_cmd  in  3  master 0 command (one-hot MNONE/MREAD/MWRITE)
m0_addr  in  AW  master 0 address
m0_wdata  in  DW  master 0 write data
m0_ack  out  1  one-cycle completion pulse to master 0
m0_rdata  out  DW  master 0 read data, valid during and after m0_ack of a read
m1_cmd  in  3  master 1 command
m1_addr  in  AW  master 1 address
m1_wdata  in  DW  master 1 write data
m1_ack  out  1  one-cycle completion pulse to master 1
m1_rdata  out  DW  master 1 read data
ram_addr  out  AW  RAM address, registered
ram_wdata  out  DW  RAM write data, registered
ram_write  out  1  RAM write enable, registered
ram_rdata  in  DW  RAM read data; synchronous RAM, valid the cycle after ram_addr is presented
busy  out  1  high whenever state != IDLE
cmd_err  out  1  sticky flag: illegal command seen

Behaviour:
- Reset values:
  - state IDLE; ram_addr 0, ram_wdata 0, ram_write 0.
  - m0_ack, m1_ack 0; m0_rdata, m1_rdata 0.
  - busy 0, cmd_err 0.
  - last_owner 1, so master 0 wins the first tie.
- Request: a master is requesting when its cmd is MREAD or MWRITE. MNONE means idle.
- Illegal command:
  - Applies to any cmd value other than the three legal codes, sampled in IDLE.
  - That master is treated as not requesting, and cmd_err is set.
  - cmd_err stays set until reset.
- States: IDLE, ACCESS, CAPTURE, DONE.
- IDLE:
  - If exactly one master is requesting, grant it.
  - If both are requesting, grant the master that is not last_owner.
  - On grant, at the edge: latch owner, cmd, addr and wdata into ram_addr/ram_wdata; set last_owner = owner; go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - ram_addr is held stable.
  - ram_write = 1 only for MWRITE; the RAM performs the write at the end of this cycle.
  - Next state: DONE for a write, CAPTURE for a read.
- CAPTURE:
  - ram_rdata is valid in this cycle.
  - At the edge it is loaded into the owner's mX_rdata.
  - Next state: DONE.
- DONE:
  - The owner's mX_ack = 1 for exactly this cycle; the other ack stays 0.
  - ram_write = 0.
  - Next state: IDLE.
- Latency, counted from the request being sampled in IDLE at cycle 0:
  - Write: ack in cycle 2.
  - Read: ack in cycle 3, with rdata valid from cycle 3.
  - mX_rdata holds its value until that master's next read completes.
- Master obligations:
  - Hold cmd/addr/wdata stable until the grant edge. Changes after the grant are ignored, because the request is latched.
  - Drop cmd to MNONE on the edge that ends the ack cycle.
  - Any non-MNONE cmd seen in the following IDLE cycle is a new transaction.
- Throughput: minimum one IDLE cycle between transactions. Back-to-back requests from both masters alternate strictly.
- A non-granted master keeps waiting; it is served at the next IDLE, and starvation is impossible.
- Reset mid-operation:
  - Returns to IDLE asynchronously and drops ram_write immediately.
  - No ack is issued; the in-flight transaction is lost.
  - last_owner returns to 1.
- Outputs are registered; there are no combinational paths from cmd inputs to RAM outputs.

Test Plan:
- Write then read: m0 MWRITE addr 9'h005 data 16'hBEEF.
  - Expect ram_write high for one cycle, m0_ack in cycle 2.
  - Then m0 MREAD 9'h005: expect m0_ack in cycle 3 with m0_rdata = 16'hBEEF.
- Tie after reset: both masters request MREAD in the same cycle.
  - m0 is served first (ack), then m1 is acked 4 cycles later.
  - Next tie goes to m0 again, since last_owner = 1.
- Continuous contention: both masters hold requests for 8 transactions.
  - Grants alternate m0, m1, m0, ...
  - The two acks are never high together, and busy drops for exactly one cycle between transactions.
- Illegal command: m1_cmd = 3'b011 in IDLE.
  - No grant and no m1_ack; cmd_err = 1 and stays 1.
  - A following legal m0 request completes normally.
- Reset during a write: assert reset while in ACCESS with ram_write = 1.
  - ram_write falls without a clock edge; state IDLE; no ack.
  - All outputs hold their reset values.
- Stability: change m0_addr from 9'h010 to 9'h020 after the grant edge.
  - The read uses 9'h010 and m0_rdata returns the RAM contents at 9'h010.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Purpose: round-robin arbiter sharing one single-port synchronous RAM between two masters.
// Latency: a request sampled in IDLE at cycle 0 acks in cycle 2 (write) or cycle 3 (read).
// Backpressure: a losing or late master just holds its cmd until it is granted at a later IDLE.
//
// Ports:
//   clk, reset           clock (rising edge) and asynchronous active-high reset
//   m0_*/m1_*            master command (one-hot MNONE/MREAD/MWRITE), address, write data,
//                        one-cycle ack pulse and read data (held until that master's next read)
//   ram_addr/wdata/write registered RAM request; ram_rdata is valid the cycle after ram_addr
//   busy                 high whenever an access is in progress
//   cmd_err              sticky flag, set when a non-one-hot command is seen in IDLE
module mem_port_arbiter #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    m0_cmd,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic [2:0]    m1_cmd,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_write,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy,
  output logic          cmd_err
);

  localparam logic [2:0] MNONE  = 3'b001;
  localparam logic [2:0] MREAD  = 3'b010;
  localparam logic [2:0] MWRITE = 3'b100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic          owner;       // master that owns the access in flight
  logic          last_owner;  // master granted most recently; loses the next tie
  logic          is_write;    // latched command type of the access in flight

  logic          m0_req;
  logic          m1_req;
  logic          m0_legal;
  logic          m1_legal;
  logic          grant;
  logic          grant_sel;
  logic          sel_write;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Request decode: any non-one-hot code counts as "not requesting".
  always_comb begin
    m0_legal = (m0_cmd == MNONE) || (m0_cmd == MREAD) || (m0_cmd == MWRITE);
    m1_legal = (m1_cmd == MNONE) || (m1_cmd == MREAD) || (m1_cmd == MWRITE);
    m0_req   = (m0_cmd == MREAD) || (m0_cmd == MWRITE);
    m1_req   = (m1_cmd == MREAD) || (m1_cmd == MWRITE);
  end

  // Round-robin pick; on a tie the master that was not served last wins.
  always_comb begin
    grant     = 1'b0;
    grant_sel = 1'b0;
    if (m0_req && m1_req) begin
      grant     = 1'b1;
      grant_sel = ~last_owner;
    end else if (m0_req) begin
      grant     = 1'b1;
      grant_sel = 1'b0;
    end else if (m1_req) begin
      grant     = 1'b1;
      grant_sel = 1'b1;
    end
  end

  always_comb begin
    sel_write = grant_sel ? (m1_cmd == MWRITE) : (m0_cmd == MWRITE);
    sel_addr  = grant_sel ? m1_addr  : m0_addr;
    sel_wdata = grant_sel ? m1_wdata : m0_wdata;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ACCESS;
      ACCESS:  state_nxt = is_write ? DONE : CAPTURE;
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs decoded from registered state only, so no input-to-output path.
  always_comb begin
    busy   = (state != IDLE);
    m0_ack = (state == DONE) && !owner;
    m1_ack = (state == DONE) &&  owner;
  end

  // Request latch and RAM interface. ram_write is high only during ACCESS:
  // it is set at the grant edge and cleared at the following edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= 1'b0;
      last_owner <= 1'b1;
      is_write   <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_write  <= 1'b0;
    end else if (state == IDLE && grant) begin
      owner      <= grant_sel;
      last_owner <= grant_sel;
      is_write   <= sel_write;
      ram_addr   <= sel_addr;
      ram_wdata  <= sel_wdata;
      ram_write  <= sel_write;
    end else begin
      ram_write  <= 1'b0;
    end
  end

  // Read data capture: ram_rdata is valid in CAPTURE and is held per master.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (state == CAPTURE) begin
      if (owner) begin
        m1_rdata <= ram_rdata;
      end else begin
        m0_rdata <= ram_rdata;
      end
    end
  end

  // Illegal commands are only judged while the arbiter is listening (IDLE).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_err <= 1'b0;
    end else if (state == IDLE && (!m0_legal || !m1_legal)) begin
      cmd_err <= 1'b1;
    end
  end

endmodule
